// File: rtl/nibble_serial_adder_pkg.sv
// nibble_serial_adder_pkg: shared FSM state encodings and sizing helpers for the nibble-serial adder
package nibble_serial_adder_pkg;
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/nibble_serial_adder_csa_4.sv
// nibble_serial_adder_csa_4: 4-bit adder slice with carry-in, carry-out and signed overflow
module nibble_serial_adder_csa_4 (
   input  logic [3:0] I_A,
   input  logic [3:0] I_B,
   input  logic       I_CI,
   output logic [3:0] O_SUM,
   output logic       O_CO,
   output logic       O_V
);
   logic [4:0] full;
   logic       c_msb;
   always_comb begin
      full  = {1'b0, I_A} + {1'b0, I_B} + {4'd0, I_CI};
      O_SUM = full[3:0];
      O_CO  = full[4];
      c_msb = I_A[3] ^ I_B[3] ^ full[3];
      O_V   = c_msb ^ full[4];
   end
endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: adds/subtracts DW-bit operands one nibble per cycle through a single 4-bit slice.
// Optional zero flag output O_Z is enabled by defining NIBBLE_SERIAL_ADDER_ZERO_FLAG_EN.
module nibble_serial_adder
   import nibble_serial_adder_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic          I_CLK,
   input  logic          I_RST,
   input  logic          I_VALID,
   output logic          O_READY,
   input  logic [DW-1:0] I_A,
   input  logic [DW-1:0] I_B,
   input  logic          I_SUB,
   output logic          O_VALID,
   input  logic          I_READY,
   output logic [DW-1:0] O_SUM,
   output logic          O_CO,
   output logic          O_V
`ifdef NIBBLE_SERIAL_ADDER_ZERO_FLAG_EN
  ,output logic          O_Z
`endif
);
   localparam int N  = DW / 4;
   localparam int CW = cnt_width(N);
   state_t        state, state_nx;
   logic [DW-1:0] a_r, b_r, acc, acc_nx;
   logic          carry;
   logic [CW-1:0] cnt;
   logic [3:0]    nib;
   logic          nib_co, nib_v;
   logic          accept, last_step;
   nibble_serial_adder_csa_4 u_csa (
      .I_A   (a_r[3:0]),
      .I_B   (b_r[3:0]),
      .I_CI  (carry),
      .O_SUM (nib),
      .O_CO  (nib_co),
      .O_V   (nib_v)
   );
   always_comb begin
      O_READY   = state == ST_IDLE;
      O_VALID   = state == ST_DONE;
      accept    = O_READY && I_VALID;
      last_step = state == ST_CALC && cnt == CW'(N - 1);
      state_nx  = accept ? ST_CALC : last_step ? ST_DONE : (O_VALID && I_READY) ? ST_IDLE : state;
      // Nibbles enter from the top so nibble k settles at bits [4k+3:4k] after N steps
      acc_nx    = (acc >> 4) | (DW'(nib) << (DW - 4));
   end
   always_ff @(posedge I_CLK) begin
      if (I_RST) state <= ST_IDLE;
      else       state <= state_nx;
   end
   always_ff @(posedge I_CLK) begin
      if (I_RST) begin
         a_r   <= '0;
         b_r   <= '0;
         acc   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         O_SUM <= '0;
         O_CO  <= 1'b0;
         O_V   <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_ZERO_FLAG_EN
         O_Z   <= 1'b0;
`endif
      end else if (accept) begin
         a_r   <= I_A;
         b_r   <= I_B ^ {DW{I_SUB}};
         carry <= I_SUB;
         cnt   <= '0;
      end else if (state == ST_CALC) begin
         a_r   <= a_r >> 4;
         b_r   <= b_r >> 4;
         acc   <= acc_nx;
         carry <= nib_co;
         cnt   <= cnt + 1'b1;
         // Result registers only change on the final step so the previous result stays visible
         if (last_step) begin
            O_SUM <= acc_nx;
            O_CO  <= nib_co;
            O_V   <= nib_v;
`ifdef NIBBLE_SERIAL_ADDER_ZERO_FLAG_EN
            O_Z   <= acc_nx == '0;
`endif
         end
      end
   end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: vector table, corner sequences and random ops checked against an arithmetic model
module tb_nibble_serial_adder;
   logic        clk = 1'b0;
   logic        rst;
   logic        i_valid, i_sub, i_ready;
   logic [31:0] i_a, i_b;
   logic        o_ready, o_valid, o_co, o_v;
   logic [31:0] o_sum;
   logic        s_valid, s_sub, s_ready;
   logic [3:0]  s_a, s_b;
   logic        s_oready, s_ovalid, s_co, s_v;
   logic [3:0]  s_sum;
`ifdef NIBBLE_SERIAL_ADDER_ZERO_FLAG_EN
   logic        o_z, s_z;
`endif
   int total = 0;
   int bad = 0;
   always #5 clk = ~clk;
   nibble_serial_adder #(.DW(32)) dut (
      .I_CLK(clk), .I_RST(rst), .I_VALID(i_valid), .O_READY(o_ready),
      .I_A(i_a), .I_B(i_b), .I_SUB(i_sub), .O_VALID(o_valid), .I_READY(i_ready),
      .O_SUM(o_sum), .O_CO(o_co), .O_V(o_v)
`ifdef NIBBLE_SERIAL_ADDER_ZERO_FLAG_EN
     ,.O_Z(o_z)
`endif
   );
   nibble_serial_adder #(.DW(4)) dut4 (
      .I_CLK(clk), .I_RST(rst), .I_VALID(s_valid), .O_READY(s_oready),
      .I_A(s_a), .I_B(s_b), .I_SUB(s_sub), .O_VALID(s_ovalid), .I_READY(s_ready),
      .O_SUM(s_sum), .O_CO(s_co), .O_V(s_v)
`ifdef NIBBLE_SERIAL_ADDER_ZERO_FLAG_EN
     ,.O_Z(s_z)
`endif
   );
   typedef struct {
      logic [31:0] a, b;
      logic        sub;
      logic [31:0] sum;
      logic        co, v;
   } vec_t;
   typedef struct {
      logic [31:0] sum;
      logic        co, v;
   } res_t;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic sub);
      res_t r;
      logic [32:0] full;
      logic [31:0] bb;
      bb    = sub ? ~b : b;
      full  = {1'b0, a} + {1'b0, bb} + {32'd0, sub};
      r.sum = full[31:0];
      r.co  = full[32];
      r.v   = sub ? (a[31] != b[31] && r.sum[31] != a[31]) : (a[31] == b[31] && r.sum[31] != a[31]);
      return r;
   endfunction
   task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic sub, output int lat);
      int g = 0;
      while (!o_ready && g < 50) begin
         @(negedge clk);
         g++;
      end
      if (!o_ready) chk("ready_timeout", 0, 1);
      i_valid = 1'b1; i_a = a; i_b = b; i_sub = sub;
      @(negedge clk);
      i_valid = 1'b0; i_a = $urandom; i_b = $urandom; i_sub = 1'($urandom);
      lat = 0;
      while (!o_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask
   task automatic finish_op(input int delay);
      repeat (delay) @(negedge clk);
      i_ready = 1'b1;
      @(negedge clk);
      i_ready = 1'b0;
      chk("hs_valid_drop", {63'd0, o_valid}, 64'd0);
      chk("hs_ready_back", {63'd0, o_ready}, 64'd1);
   endtask
   task automatic run_check(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic sub, input logic [31:0] es, input logic eco, input logic ev, input int delay);
      int lat;
      start_op(a, b, sub, lat);
      chk({name, "_lat"}, 64'(lat), 64'd8);
      chk({name, "_sum"}, {32'd0, o_sum}, {32'd0, es});
      chk({name, "_co"}, {63'd0, o_co}, {63'd0, eco});
      chk({name, "_v"}, {63'd0, o_v}, {63'd0, ev});
`ifdef NIBBLE_SERIAL_ADDER_ZERO_FLAG_EN
      chk({name, "_z"}, {63'd0, o_z}, {63'd0, es == 32'd0});
`endif
      finish_op(delay);
   endtask
   initial begin
      vec_t vt[6];
      res_t r;
      int lat;
      logic [31:0] held;
      vt[0] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
      vt[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
      vt[2] = '{32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
      vt[3] = '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
      vt[4] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};
      vt[5] = '{32'h12345678, 32'h0FEDCBA8, 1'b0, 32'h22222220, 1'b0, 1'b0};
      rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_a = '0; i_b = '0; i_sub = 1'b0;
      s_valid = 1'b0; s_ready = 1'b0; s_a = '0; s_b = '0; s_sub = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_ready", {63'd0, o_ready}, 64'd1);
      chk("rst_valid", {63'd0, o_valid}, 64'd0);
      chk("rst_sum", {32'd0, o_sum}, 64'd0);
      chk("rst_co_v", {62'd0, o_co, o_v}, 64'd0);
`ifdef NIBBLE_SERIAL_ADDER_ZERO_FLAG_EN
      chk("rst_z", {63'd0, o_z}, 64'd0);
`endif
      for (int i = 0; i < 6; i++) run_check($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].sub, vt[i].sum, vt[i].co, vt[i].v, i % 3);
      // Stall in DONE while a new request is presented
      start_op(32'h00000100, 32'h00000023, 1'b0, lat);
      chk("stall_lat", 64'(lat), 64'd8);
      held = o_sum;
      chk("stall_sum0", {32'd0, held}, 64'h123);
      for (int i = 0; i < 5; i++) begin
         i_valid = 1'b1; i_a = $urandom; i_b = $urandom; i_sub = 1'($urandom);
         @(negedge clk);
         chk("stall_sum", {32'd0, o_sum}, {32'd0, held});
         chk("stall_ready", {62'd0, o_ready, o_valid}, 64'd1);
      end
      i_valid = 1'b0;
      finish_op(0);
      repeat (3) @(negedge clk);
      chk("hold_after_hs", {32'd0, o_sum}, {32'd0, held});
      chk("hold_no_valid", {63'd0, o_valid}, 64'd0);
      // Reset during the fourth CALC cycle discards the operation
      i_valid = 1'b1; i_a = 32'hAAAAAAAA; i_b = 32'h11111111; i_sub = 1'b0;
      @(negedge clk);
      i_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_ready", {63'd0, o_ready}, 64'd1);
      chk("midrst_valid", {63'd0, o_valid}, 64'd0);
      chk("midrst_sum", {32'd0, o_sum}, 64'd0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (o_valid) chk("midrst_pulse", 64'd1, 64'd0);
      end
      run_check("post_rst", 32'h00000010, 32'h00000020, 1'b0, 32'h00000030, 1'b0, 1'b0, 0);
      for (int i = 0; i < 40; i++) begin
         logic [31:0] a, b;
         logic sub;
         a = $urandom; b = $urandom; sub = 1'($urandom);
         if (i % 5 == 0) b = a;
         r = model(a, b, sub);
         run_check($sformatf("rnd%0d", i), a, b, sub, r.sum, r.co, r.v, int'($urandom_range(0, 2)));
      end
      // DW=4 instance: one CALC cycle
      s_valid = 1'b1; s_a = 4'h7; s_b = 4'h1; s_sub = 1'b0;
      @(negedge clk);
      s_valid = 1'b0;
      chk("dw4_not_yet", {63'd0, s_ovalid}, 64'd0);
      @(negedge clk);
      chk("dw4_valid", {63'd0, s_ovalid}, 64'd1);
      chk("dw4_sum", {60'd0, s_sum}, 64'h8);
      chk("dw4_co_v", {62'd0, s_co, s_v}, 64'd1);
      s_ready = 1'b1;
      @(negedge clk);
      s_ready = 1'b0;
      chk("dw4_idle", {62'd0, s_oready, s_ovalid}, 64'd2);
      s_valid = 1'b1; s_a = 4'h3; s_b = 4'h5; s_sub = 1'b1;
      @(negedge clk);
      s_valid = 1'b0;
      @(negedge clk);
      chk("dw4_sub", {59'd0, s_co, s_sum}, {59'd0, 1'b0, 4'hE});
      s_ready = 1'b1;
      @(negedge clk);
      s_ready = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
